oam_dma: RTL

OAM_DMA -- requirements
Module: oam_dma

---
 rtl/oam_dma.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/oam_dma.sv
// ---------------------------------------------------------------------------
// oam_dma -- sprite attribute DMA engine triggered by a CPU write to $4014.
//
// A CPU write latches a source page; the engine then stalls the CPU and
// copies XFER_LEN bytes from RAM page {page, 00..} into OAM, one byte every
// two cycles (READ then WRITE). An optional idle cycle (ALIGN) is inserted
// when the triggering write landed on an odd CPU cycle.
//
// Optional feature: define OAM_DMA_ABORT_EN to add an 'abort' input that
// cancels a running transfer after finishing the byte in flight.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   cpu_wr            one-cycle strobe, CPU write to $4014
//   cpu_wdata[7:0]    source page, sampled with cpu_wr
//   cpu_odd           CPU cycle parity, sampled with cpu_wr
//   abort             (OAM_DMA_ABORT_EN only) cancel the transfer
//   cpu_halt          stalls the CPU while the DMA owns the bus
//   ram_addr[15:0]    RAM address
//   ram_rdata[7:0]    RAM read data (registered by the RAM)
//   ram_rw_n          RAM read/write select (always read)
//   ram_cs_n          RAM chip select, active-low
//   oam_addr[7:0]     OAM write address
//   oam_wdata[7:0]    OAM write data
//   oam_we            OAM write enable, one cycle per byte
//   busy              high from acceptance until back in IDLE
//   done              one-cycle pulse after a complete transfer
// ---------------------------------------------------------------------------
module oam_dma #(
    parameter int XFER_LEN = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_odd,
`ifdef OAM_DMA_ABORT_EN
    input  logic        abort,
`endif
    output logic        cpu_halt,
    output logic [15:0] ram_addr,
    input  logic [7:0]  ram_rdata,
    output logic        ram_rw_n,
    output logic        ram_cs_n,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata,
    output logic        oam_we,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_ALIGN,
        S_READ,
        S_WRITE
    } state_t;

    // Nine bits so that a full 256-byte transfer can reach its terminal count.
    localparam logic [8:0] LAST_COUNT = 9'(XFER_LEN);

    state_t     state;
    logic [8:0] count;
    logic [8:0] count_nxt;
    logic [7:0] page;
    logic       odd_q;
    logic       abort_pend;
    logic       abort_in;

`ifdef OAM_DMA_ABORT_EN
    assign abort_in = abort;
`else
    assign abort_in = 1'b0;
`endif

    assign count_nxt = count + 9'd1;

    // The DMA never writes RAM.
    assign ram_rw_n  = 1'b1;
    assign cpu_halt  = busy;
    // RAM data is registered, so it is valid during WRITE and is forwarded
    // straight to OAM for the cycle oam_we is high.
    assign oam_wdata = oam_we ? ram_rdata : 8'h00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            count      <= 9'd0;
            page       <= 8'h00;
            odd_q      <= 1'b0;
            abort_pend <= 1'b0;
            ram_addr   <= 16'h0000;
            ram_cs_n   <= 1'b1;
            oam_addr   <= 8'h00;
            oam_we     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (cpu_wr) begin
                        page       <= cpu_wdata;
                        odd_q      <= cpu_odd;
                        count      <= 9'd0;
                        abort_pend <= 1'b0;
                        busy       <= 1'b1;
                        state      <= S_HALT;
                    end
                end
                S_HALT: begin
                    if (abort_in) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else if (odd_q) begin
                        state <= S_ALIGN;
                    end else begin
                        ram_addr <= {page, count[7:0]};
                        ram_cs_n <= 1'b0;
                        state    <= S_READ;
                    end
                end
                S_ALIGN: begin
                    if (abort_in) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        ram_addr <= {page, count[7:0]};
                        ram_cs_n <= 1'b0;
                        state    <= S_READ;
                    end
                end
                S_READ: begin
                    // Address and chip select stay asserted through WRITE so
                    // the registered RAM keeps driving the data bus.
                    oam_addr <= count[7:0];
                    oam_we   <= 1'b1;
                    if (abort_in) begin
                        abort_pend <= 1'b1;
                    end
                    state <= S_WRITE;
                end
                S_WRITE: begin
                    oam_we <= 1'b0;
                    count  <= count_nxt;
                    if (abort_in || abort_pend) begin
                        abort_pend <= 1'b0;
                        ram_cs_n   <= 1'b1;
                        busy       <= 1'b0;
                        state      <= S_IDLE;
                    end else if (count_nxt == LAST_COUNT) begin
                        ram_cs_n <= 1'b1;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= S_IDLE;
                    end else begin
                        // Only the low byte advances; the page never changes.
                        ram_addr <= {page, count_nxt[7:0]};
                        state    <= S_READ;
                    end
                end
                default: begin
                    busy     <= 1'b0;
                    ram_cs_n <= 1'b1;
                    oam_we   <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule
